// File: rtl/inst_mem_writer_if.sv
// Loader-side bus of the instruction-memory writer: instruction handshake in, byte-write port and status out.
// master = program loader / debug path, slave = inst_mem_writer.
interface inst_mem_writer_if #(
  parameter int CNT_W = 16
);
  logic             base_load;
  logic [31:0]      base_addr;
  logic             in_valid;
  logic             in_ready;
  logic [47:0]      in_inst;
  logic             in_mode;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_datain;
  logic [31:0]      wr_ptr;
  logic             busy;
  logic             inst_done;
  logic [CNT_W-1:0] inst_count;

  modport master (
    output base_load, base_addr, in_valid, in_inst, in_mode,
    input  in_ready, mem_we, mem_addr, mem_datain, wr_ptr, busy, inst_done, inst_count
  );

  modport slave (
    input  base_load, base_addr, in_valid, in_inst, in_mode,
    output in_ready, mem_we, mem_addr, mem_datain, wr_ptr, busy, inst_done, inst_count
  );
endinterface

// File: rtl/inst_mem_writer.sv
// Serialises 1..6-byte instructions into byte-wide instruction memory, LSB first; byte 0 appears the cycle after accept.
// in_ready drops while an instruction is mid-write and re-opens on its last byte for zero-bubble back-to-back accepts.
module inst_mem_writer #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  inst_mem_writer_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [47:0]      inst_q, inst_d;
  logic [2:0]       len_q, len_d;
  logic [2:0]       off_q, off_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_dat_q, mem_dat_d;
  logic             done_q, done_d;

  logic             last;
  logic             in_rdy;
  logic             accept;
  logic [47:0]      inst_shift;

  // Variable-length encoding: byte count is selected by the opcode nibble in byte 0.
  function automatic logic [2:0] var_len(input logic [3:0] op);
    logic [2:0] l;
    case (op)
      4'h0, 4'h1, 4'h9, 4'hD, 4'hE, 4'hF: l = 3'd1;
      4'h2, 4'h6, 4'hA, 4'hB:             l = 3'd2;
      4'h7, 4'h8, 4'hC:                   l = 3'd5;
      default:                            l = 3'd6;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    inst_d   = inst_q;
    len_d    = len_q;
    off_d    = off_q;

    last   = (state_q == WRITE) && (off_q == (len_q - 3'd1));
    in_rdy = !bus.base_load && ((state_q == IDLE) || last);
    accept = bus.in_valid && in_rdy;

    if (bus.base_load) begin
      // Abandon any partial instruction; the count restarts with the new region.
      state_d  = IDLE;
      wr_ptr_d = bus.base_addr;
      cnt_d    = '0;
      off_d    = 3'd0;
    end else begin
      if (state_q == WRITE) begin
        wr_ptr_d = wr_ptr_q + 32'd1;
        off_d    = off_q + 3'd1;
        if (last) begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = IDLE;
        end
      end
      if (accept) begin
        inst_d  = bus.in_inst;
        len_d   = bus.in_mode ? var_len(bus.in_inst[7:4]) : 3'd4;
        off_d   = 3'd0;
        state_d = WRITE;
      end
    end

    // Memory-port outputs are registered from next-state values so they line up with the state they describe.
    inst_shift = inst_d >> {off_d, 3'b000};
    mem_we_d   = (state_d == WRITE);
    mem_addr_d = mem_we_d ? wr_ptr_d : 32'd0;
    mem_dat_d  = mem_we_d ? inst_shift[7:0] : 8'd0;
    done_d     = mem_we_d && (off_d == (len_d - 3'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 32'd0;
      cnt_q      <= '0;
      inst_q     <= 48'd0;
      len_q      <= 3'd0;
      off_q      <= 3'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_dat_q  <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      len_q      <= len_d;
      off_q      <= off_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_dat_q  <= mem_dat_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_datain = mem_dat_q;
  assign bus.wr_ptr     = wr_ptr_q;
  assign bus.busy       = (state_q == WRITE);
  assign bus.inst_done  = done_q;
  assign bus.inst_count = cnt_q;

endmodule

// File: tb/tb_inst_mem_writer.sv
// Bench for inst_mem_writer: directed vector table, corner sequences, then random traffic against a byte-queue model.
module tb_inst_mem_writer;

  logic clk;
  logic reset;

  inst_mem_writer_if #(.CNT_W(16)) bus ();

  inst_mem_writer #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        done;
    logic        rdy;
    logic [31:0] addr;
    logic [7:0]  dat;
    logic [31:0] ptr;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic        bl;
    logic [31:0] ba;
    logic        v;
    logic [47:0] inst;
    logic        md;
    obs_t        exp;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } mbyte_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: bytes still owed to memory, plus pointer and instruction count.
  mbyte_t      q[$];
  logic [31:0] m_ptr;
  logic [15:0] m_cnt;
  int          len_tbl [16] = '{1, 1, 2, 6, 6, 6, 2, 5, 5, 1, 2, 2, 5, 1, 1, 1};

  vec_t tbl [27];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic bl, input logic [31:0] ba, input logic v,
                              input logic [47:0] inst, input logic md,
                              input logic we, input logic [31:0] addr, input logic [7:0] dat,
                              input logic done, input logic rdy, input logic [31:0] ptr,
                              input logic [15:0] cnt);
    vec_t r;
    r.bl = bl; r.ba = ba; r.v = v; r.inst = inst; r.md = md;
    r.exp.we = we; r.exp.addr = addr; r.exp.dat = dat; r.exp.done = done;
    r.exp.rdy = rdy; r.exp.ptr = ptr; r.exp.cnt = cnt;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr = 32'd0;
    m_cnt = 16'd0;
  endtask

  // One clock cycle: drive at the falling edge, compare against the model, then advance the model.
  task automatic cycle(input logic bl, input logic [31:0] ba, input logic v,
                       input logic [47:0] inst, input logic md, output obs_t o);
    logic        e_we, e_done, e_rdy;
    logic [31:0] e_addr;
    logic [7:0]  e_dat;
    mbyte_t      t;
    int          n;
    @(negedge clk);
    bus.base_load = bl;
    bus.base_addr = ba;
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_mode   = md;
    #1;
    e_we = (q.size() > 0);
    e_addr = 32'd0; e_dat = 8'd0; e_done = 1'b0;
    if (e_we) begin
      e_addr = m_ptr;
      e_dat  = q[0].b;
      e_done = q[0].last;
    end
    e_rdy = !bl && (q.size() <= 1);
    chk("mem_we",     {63'd0, bus.mem_we},     {63'd0, e_we});
    chk("mem_addr",   {32'd0, bus.mem_addr},   {32'd0, e_addr});
    chk("mem_datain", {56'd0, bus.mem_datain}, {56'd0, e_dat});
    chk("inst_done",  {63'd0, bus.inst_done},  {63'd0, e_done});
    chk("in_ready",   {63'd0, bus.in_ready},   {63'd0, e_rdy});
    chk("busy",       {63'd0, bus.busy},       {63'd0, e_we});
    chk("wr_ptr",     {32'd0, bus.wr_ptr},     {32'd0, m_ptr});
    chk("inst_count", {48'd0, bus.inst_count}, {48'd0, m_cnt});
    o.we = bus.mem_we; o.done = bus.inst_done; o.rdy = bus.in_ready;
    o.addr = bus.mem_addr; o.dat = bus.mem_datain; o.ptr = bus.wr_ptr; o.cnt = bus.inst_count;
    if (e_we) begin
      t = q.pop_front();
      m_ptr = m_ptr + 32'd1;
      if (t.last) m_cnt = m_cnt + 16'd1;
    end
    if (bl) begin
      q.delete();
      m_ptr = ba;
      m_cnt = 16'd0;
    end else if (v && e_rdy) begin
      n = md ? len_tbl[inst[7:4]] : 4;
      for (int k = 0; k < n; k++) begin
        t.b    = inst[8*k +: 8];
        t.last = (k == n - 1);
        q.push_back(t);
      end
    end
  endtask

  task automatic idle(output obs_t o);
    cycle(1'b0, 32'd0, 1'b0, 48'd0, 1'b0, o);
  endtask

  initial begin
    obs_t        o;
    int          we_n, done_n;
    logic [31:0] r1, r2, ba;
    logic [31:0] wrap_exp [4];

    reset = 1'b1;
    bus.base_load = 1'b0; bus.base_addr = 32'd0; bus.in_valid = 1'b0;
    bus.in_inst = 48'd0;  bus.in_mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_we",     {63'd0, bus.mem_we},     64'd0);
    chk("rst mem_addr",   {32'd0, bus.mem_addr},   64'd0);
    chk("rst mem_datain", {56'd0, bus.mem_datain}, 64'd0);
    chk("rst busy",       {63'd0, bus.busy},       64'd0);
    chk("rst inst_done",  {63'd0, bus.inst_done},  64'd0);
    chk("rst in_ready",   {63'd0, bus.in_ready},   64'd1);
    chk("rst wr_ptr",     {32'd0, bus.wr_ptr},     64'd0);
    chk("rst inst_count", {48'd0, bus.inst_count}, 64'd0);
    reset = 1'b0;

    // bl, ba, v, inst, md | we, addr, dat, done, rdy, ptr, cnt
    tbl[0]  = mk(1, 32'h100, 0, 48'h0, 0,             0, 32'h0,   8'h00, 0, 0, 32'h0,   0);
    tbl[1]  = mk(0, 0, 1, 48'h0000_DDCC_BBAA, 0,       0, 32'h0,   8'h00, 0, 1, 32'h100, 0);
    tbl[2]  = mk(0, 0, 0, 48'h0, 0,                    1, 32'h100, 8'hAA, 0, 0, 32'h100, 0);
    tbl[3]  = mk(0, 0, 0, 48'h0, 0,                    1, 32'h101, 8'hBB, 0, 0, 32'h101, 0);
    tbl[4]  = mk(0, 0, 0, 48'h0, 0,                    1, 32'h102, 8'hCC, 0, 0, 32'h102, 0);
    tbl[5]  = mk(0, 0, 0, 48'h0, 0,                    1, 32'h103, 8'hDD, 1, 1, 32'h103, 0);
    tbl[6]  = mk(0, 0, 1, 48'h6655_4433_2230, 1,       0, 32'h0,   8'h00, 0, 1, 32'h104, 1);
    tbl[7]  = mk(0, 0, 0, 48'h0, 0,                    1, 32'h104, 8'h30, 0, 0, 32'h104, 1);
    tbl[8]  = mk(0, 0, 0, 48'h0, 0,                    1, 32'h105, 8'h22, 0, 0, 32'h105, 1);
    tbl[9]  = mk(0, 0, 0, 48'h0, 0,                    1, 32'h106, 8'h33, 0, 0, 32'h106, 1);
    tbl[10] = mk(0, 0, 0, 48'h0, 0,                    1, 32'h107, 8'h44, 0, 0, 32'h107, 1);
    tbl[11] = mk(0, 0, 0, 48'h0, 0,                    1, 32'h108, 8'h55, 0, 0, 32'h108, 1);
    tbl[12] = mk(0, 0, 1, 48'hEE99_8877_6675, 1,       1, 32'h109, 8'h66, 1, 1, 32'h109, 1);
    tbl[13] = mk(0, 0, 0, 48'h0, 0,                    1, 32'h10A, 8'h75, 0, 0, 32'h10A, 2);
    tbl[14] = mk(0, 0, 0, 48'h0, 0,                    1, 32'h10B, 8'h66, 0, 0, 32'h10B, 2);
    tbl[15] = mk(0, 0, 0, 48'h0, 0,                    1, 32'h10C, 8'h77, 0, 0, 32'h10C, 2);
    tbl[16] = mk(0, 0, 0, 48'h0, 0,                    1, 32'h10D, 8'h88, 0, 0, 32'h10D, 2);
    tbl[17] = mk(0, 0, 1, 48'h1111_1111_11D5, 1,       1, 32'h10E, 8'h99, 1, 1, 32'h10E, 2);
    tbl[18] = mk(0, 0, 0, 48'h0, 0,                    1, 32'h10F, 8'hD5, 1, 1, 32'h10F, 3);
    tbl[19] = mk(1, 32'h120, 1, 48'hFFFF_FFFF_FF09, 1, 0, 32'h0,   8'h00, 0, 0, 32'h110, 4);
    tbl[20] = mk(0, 0, 1, 48'hFFFF_FFFF_FF01, 1,       0, 32'h0,   8'h00, 0, 1, 32'h120, 0);
    tbl[21] = mk(0, 0, 1, 48'hFFFF_FFFF_FF02, 1,       1, 32'h120, 8'h01, 1, 1, 32'h120, 0);
    tbl[22] = mk(0, 0, 1, 48'hFFFF_FFFF_FF03, 1,       1, 32'h121, 8'h02, 1, 1, 32'h121, 1);
    tbl[23] = mk(0, 0, 1, 48'hFFFF_FFFF_FF04, 1,       1, 32'h122, 8'h03, 1, 1, 32'h122, 2);
    tbl[24] = mk(0, 0, 1, 48'hFFFF_FFFF_FF05, 1,       1, 32'h123, 8'h04, 1, 1, 32'h123, 3);
    tbl[25] = mk(0, 0, 0, 48'h0, 0,                    1, 32'h124, 8'h05, 1, 1, 32'h124, 4);
    tbl[26] = mk(0, 0, 0, 48'h0, 0,                    0, 32'h0,   8'h00, 0, 1, 32'h125, 5);

    for (int i = 0; i < 27; i++) begin
      cycle(tbl[i].bl, tbl[i].ba, tbl[i].v, tbl[i].inst, tbl[i].md, o);
      chk($sformatf("tbl%0d we", i),   {63'd0, o.we},   {63'd0, tbl[i].exp.we});
      chk($sformatf("tbl%0d addr", i), {32'd0, o.addr}, {32'd0, tbl[i].exp.addr});
      chk($sformatf("tbl%0d dat", i),  {56'd0, o.dat},  {56'd0, tbl[i].exp.dat});
      chk($sformatf("tbl%0d done", i), {63'd0, o.done}, {63'd0, tbl[i].exp.done});
      chk($sformatf("tbl%0d rdy", i),  {63'd0, o.rdy},  {63'd0, tbl[i].exp.rdy});
      chk($sformatf("tbl%0d ptr", i),  {32'd0, o.ptr},  {32'd0, tbl[i].exp.ptr});
      chk($sformatf("tbl%0d cnt", i),  {48'd0, o.cnt},  {48'd0, tbl[i].exp.cnt});
    end

    // base_load lands while byte 1 of a 6-byte instruction is on the port.
    cycle(1'b1, 32'h300, 1'b0, 48'd0, 1'b0, o);
    cycle(1'b0, 32'd0, 1'b1, 48'h0605_0403_0231, 1'b1, o);
    we_n = 0; done_n = 0;
    idle(o);
    we_n += int'(o.we); done_n += int'(o.done);
    cycle(1'b1, 32'h200, 1'b0, 48'd0, 1'b0, o);
    we_n += int'(o.we); done_n += int'(o.done);
    idle(o);
    we_n += int'(o.we); done_n += int'(o.done);
    chk("abort bytes written", 64'(we_n), 64'd2);
    chk("abort inst_done",     64'(done_n), 64'd0);
    chk("abort wr_ptr",        {32'd0, o.ptr}, 64'h200);
    chk("abort inst_count",    {48'd0, o.cnt}, 64'd0);
    cycle(1'b0, 32'd0, 1'b1, 48'h0000_0D0C_0B0A, 1'b0, o);
    idle(o);
    chk("abort next addr", {32'd0, o.addr}, 64'h200);
    repeat (4) idle(o);

    // Pointer wrap inside one instruction.
    wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 48'd0, 1'b0, o);
    cycle(1'b0, 32'd0, 1'b1, 48'hAAAA_4433_2211, 1'b0, o);
    for (int k = 0; k < 4; k++) begin
      idle(o);
      chk($sformatf("wrap addr%0d", k), {32'd0, o.addr}, {32'd0, wrap_exp[k]});
    end
    chk("wrap done", {63'd0, o.done}, 64'd1);
    idle(o);
    chk("wrap wr_ptr", {32'd0, o.ptr}, 64'd2);

    // Asynchronous reset while byte 1 is on the port.
    cycle(1'b0, 32'd0, 1'b1, 48'h0000_8877_6655, 1'b0, o);
    idle(o);
    idle(o);
    chk("pre-reset we", {63'd0, o.we}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async rst mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("async rst wr_ptr", {32'd0, bus.wr_ptr}, 64'd0);
    chk("async rst busy",   {63'd0, bus.busy},   64'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    idle(o);
    chk("post-reset in_ready", {63'd0, o.rdy}, 64'd1);
    chk("post-reset we",       {63'd0, o.we},  64'd0);

    // Random traffic, including loads near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      ba = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
      cycle(($urandom_range(0, 39) == 0), ba, ($urandom_range(0, 3) != 0),
            {r1[15:0], r2}, 1'($urandom_range(0, 1)), o);
    end
    repeat (8) idle(o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
